// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store read-modify-write controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Size 2'b11 has no enum member and is always rejected here.
    function automatic logic bad_size_or_align(input logic [1:0] size, input logic [1:0] lo);
        return (size == 2'b11)
            || ((size == SZ_H) && lo[0])
            || ((size == SZ_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{byte_off, 3'b000} +: 8];
    assign half_sel = word[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        load_data = word;
        merged    = word;
        case (size)
            SZ_B: begin
                load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                merged[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_rmw_ctrl.sv
// Load/store unit front end: validates core requests and sequences single-word
// reads, whole-word writes and read-modify-write for byte/half stores.
//
// state    | meaning
// ST_IDLE  | ready; latch request and classify it
// ST_READ  | one-cycle DMEM read; capture load data or merged store word
// ST_WRITE | one-cycle DMEM write of the full word
// ST_RESP  | one-cycle response pulse
module lsu_rmw_ctrl
    import lsu_pkg::*;
#(
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        write_q;
    logic        err_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_err = bad_size_or_align(req_size, req_addr[1:0])
                  || ({2'b00, req_addr[31:2]} >= 32'(DMEM_WORDS));

    lsu_align u_align (
        .word        (mem_rdata),
        .byte_off    (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        rdata_q <= '0;
                        if (req_err)
                            state <= ST_RESP;
                        else if (req_write && (req_size == SZ_W))
                            state <= ST_WRITE;
                        else
                            state <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Stores reuse wdata_q to carry the merged word into WRITE.
                    if (write_q) begin
                        wdata_q <= merged;
                        state   <= ST_WRITE;
                    end else begin
                        rdata_q <= load_data;
                        state   <= ST_RESP;
                    end
                end
                ST_WRITE: state <= ST_RESP;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = (state == ST_RESP) && err_q;
    assign rsp_rdata = (state == ST_RESP) ? rdata_q : '0;
    assign mem_read  = (state == ST_READ);
    assign mem_write = (state == ST_WRITE);
    assign mem_addr  = ((state == ST_READ) || (state == ST_WRITE)) ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wdata = (state == ST_WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Directed bench for lsu_rmw_ctrl with a 256-word behavioural data memory.
module tb_lsu_rmw_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] dmem [0:255];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_acc    = 0;

    int          lat;
    int          n_rd;
    int          n_wr;
    logic        got_rsp;
    logic [31:0] r_data;
    logic        r_err;
    logic [31:0] wr_data;
    logic [31:0] wr_addr;

    lsu_rmw_ctrl #(.DMEM_WORDS(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr[9:2]] <= mem_wdata;
        if (req_valid && req_ready && !rst_n) n_acc <= n_acc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to its response (bounded).
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; n_rd = 0; n_wr = 0; got_rsp = 1'b0;
        r_data = '0; r_err = 1'b0; wr_data = '0; wr_addr = '0;
        for (int c = 0; c < 10; c++) begin
            if (mem_read) n_rd++;
            if (mem_write) begin
                n_wr++;
                wr_data = mem_wdata;
                wr_addr = mem_addr;
            end
            if (rsp_valid) begin
                got_rsp = 1'b1;
                r_data  = rsp_rdata;
                r_err   = rsp_err;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    logic [31:0] b2b_addr [4];
    logic [1:0]  b2b_size [4];
    logic        b2b_uns  [4];
    logic [31:0] b2b_exp  [4];
    logic [31:0] b2b_got  [4];

    initial begin
        int idx;
        int n_rsp;
        int n_err;
        int n_extra;

        for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
        dmem[4]  = 32'h8899AABB;
        dmem[12] = 32'h11223344;

        rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_rw",    {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr",  mem_addr, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;

        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        check("lb_data", r_data, 32'hFFFFFFAA);
        check("lb_lat",  32'(lat), 32'd2);
        check("lb_err",  32'(r_err), 32'd0);

        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        check("lbu_data", r_data, 32'h000000AA);

        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CC);
        check("sb_wdata", wr_data, 32'h8899CCBB);
        check("sb_waddr", wr_addr, 32'h10);
        check("sb_lat",   32'(lat), 32'd3);
        check("sb_rw",    32'(n_rd * 10 + n_wr), 32'd11);
        check("sb_rdata", r_data, 32'h0);

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_after_sb", r_data, 32'h8899CCBB);
        check("lw_lat",      32'(lat), 32'd2);

        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
        check("sw_rw",  32'(n_rd * 10 + n_wr), 32'd1);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_err", 32'(r_err), 32'd0);
        check("sw_mem", dmem[8], 32'hDEADBEEF);

        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        check("lh_data", r_data, 32'hFFFFDEAD);
        do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        check("lhu_data", r_data, 32'h0000BEEF);

        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        check("err_lw13", {r_err, 7'd0, 8'(lat), 8'(n_rd), 8'(n_wr)}, {1'b1, 7'd0, 8'd1, 8'd0, 8'd0});
        do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
        check("err_lh21", {r_err, 7'd0, 8'(lat), 8'(n_rd), 8'(n_wr)}, {1'b1, 7'd0, 8'd1, 8'd0, 8'd0});
        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678);
        check("err_sz11", {r_err, 7'd0, 8'(lat), 8'(n_rd), 8'(n_wr)}, {1'b1, 7'd0, 8'd1, 8'd0, 8'd0});
        check("err_sz11_mem", dmem[4], 32'h8899CCBB);
        do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        check("err_range", {r_err, 7'd0, 8'(lat), 8'(n_rd), 8'(n_wr)}, {1'b1, 7'd0, 8'd1, 8'd0, 8'd0});
        check("err_rdata", r_data, 32'h0);

        // Reset in the WRITE phase of sh 0x30 must suppress the write.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h30; req_wdata = 32'h00005555;
        @(negedge clk);
        req_valid = 1'b0;
        check("sh_read_phase", 32'(mem_read), 32'd1);
        @(negedge clk);
        check("sh_write_phase", {31'd0, mem_write}, 32'd1);
        check("sh_merge", mem_wdata, 32'h11225555);
        #2 rst_n = 1'b1;
        #1;
        check("rstw_mem_write", 32'(mem_write), 32'd0);
        check("rstw_ready",     32'(req_ready), 32'd1);
        check("rstw_mem_out",   mem_addr | mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        n_extra = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) n_extra++;
            @(negedge clk);
        end
        check("rstw_no_rsp", 32'(n_extra), 32'd0);
        check("rstw_mem_kept", dmem[12], 32'h11223344);

        // Reset in the READ phase discards the access.
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h30;
        @(negedge clk);
        req_valid = 1'b0;
        check("lw_read_phase", 32'(mem_read), 32'd1);
        #2 rst_n = 1'b1;
        #1;
        check("rstr_mem_read", 32'(mem_read), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        n_extra = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) n_extra++;
            @(negedge clk);
        end
        check("rstr_no_rsp", 32'(n_extra), 32'd0);

        // Back-to-back with req_valid held high; junk fields while not ready.
        b2b_addr[0] = 32'h10; b2b_size[0] = 2'b10; b2b_uns[0] = 1'b0; b2b_exp[0] = 32'h8899CCBB;
        b2b_addr[1] = 32'h20; b2b_size[1] = 2'b10; b2b_uns[1] = 1'b0; b2b_exp[1] = 32'hDEADBEEF;
        b2b_addr[2] = 32'h30; b2b_size[2] = 2'b10; b2b_uns[2] = 1'b0; b2b_exp[2] = 32'h11223344;
        b2b_addr[3] = 32'h12; b2b_size[3] = 2'b00; b2b_uns[3] = 1'b1; b2b_exp[3] = 32'h00000099;
        for (int i = 0; i < 4; i++) b2b_got[i] = 32'hX;
        idx = 0; n_rsp = 0; n_err = 0;
        n_acc = 0;
        for (int c = 0; c < 40 && n_rsp < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (n_rsp < 4) b2b_got[n_rsp] = rsp_rdata;
                if (rsp_err) n_err++;
                n_rsp++;
            end
            if (idx < 4) begin
                req_valid = 1'b1; req_write = 1'b0;
                if (req_ready) begin
                    req_addr = b2b_addr[idx]; req_size = b2b_size[idx];
                    req_unsigned = b2b_uns[idx];
                    idx++;
                end else begin
                    req_addr = 32'h13; req_size = 2'b11; req_unsigned = 1'b0;
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_acc",   32'(n_acc), 32'd4);
        check("b2b_rsp",   32'(n_rsp), 32'd4);
        check("b2b_err",   32'(n_err), 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("b2b_data%0d", i), b2b_got[i], b2b_exp[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_rmw_ctrl.md
LSU_RMW_CTRL -- requirements
Module: lsu_rmw_ctrl

Interface
REQ-001 Parameter DMEM_WORDS, default 256: number of 32-bit words in the downstream data memory; word index = addr[9:2].
REQ-002 The port list SHALL be, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1).
- req_valid  in  1  core access request.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 illegal.
- req_unsigned  in  1  zero-extend loads (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; misaligned, illegal size or out of range.
- mem_read  out  1  to DMEM MemRead.
- mem_write  out  1  to DMEM MemWrite.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  DMEM combinational read data.

Function
REQ-003 The FSM SHALL have states IDLE, READ, WRITE and RESP; req_ready = 1 only in IDLE.
REQ-004 In IDLE, when req_valid = 1, the block SHALL latch all req_* fields and branch on the request type:
- error -> RESP with rsp_err = 1, no memory access.
- load or sub-word store -> READ.
- word store -> WRITE.
REQ-005 An error SHALL be flagged for any of:
- req_size = 11.
- half access with addr[0] = 1.
- word access with addr[1:0] != 00.
- addr[31:2] >= DMEM_WORDS.
REQ-006 READ SHALL assert mem_read = 1 for exactly one cycle and register mem_rdata at the end of that cycle.
REQ-007 After READ, a load SHALL go to RESP and a sub-word store SHALL go to WRITE.
REQ-008 WRITE SHALL assert mem_write = 1 for exactly one cycle with mem_wdata = the merged word, then go to RESP.
REQ-009 RESP SHALL assert rsp_valid = 1 for exactly one cycle, then go to IDLE; a new request is accepted the following cycle.
REQ-010 Latency from the acceptance cycle to rsp_valid SHALL be:
- load: 2 cycles.
- word store: 2 cycles.
- byte/half store: 3 cycles.
- error: 1 cycle.
REQ-011 Load extraction SHALL use addr[1:0]:
- Byte lane = addr[1:0], half lane = addr[1].
- Signed loads sign-extend to 32 bits; unsigned loads zero-extend.
- Word loads pass through unchanged.
REQ-012 Store merge SHALL replace only the addressed byte or half lane with the low bits of req_wdata; all other lanes keep the word read in READ.
REQ-013 mem_addr SHALL hold the latched word-aligned address in READ and WRITE; all mem_* outputs are 0 in IDLE and RESP.
REQ-014 mem_read and mem_write SHALL be decoded from the registered state only, never both 1.
REQ-015 While req_ready = 0, req_valid and req_* changes SHALL be ignored.

Reset
REQ-016 Assertion of rst_n SHALL immediately force, independent of clk:
- state = IDLE.
- req_ready = 1.
- rsp_valid, rsp_err, mem_read, mem_write = 0.
- rsp_rdata, mem_addr, mem_wdata = 0.
REQ-017 Reset asserted during WRITE SHALL suppress that write (mem_write is 0 at the next edge); reset during READ SHALL discard the access with no response.

Structure
REQ-018 Package lsu_pkg SHALL hold the size encoding enum (SZ_B, SZ_H, SZ_W) and the state enum.
REQ-019 Sub-module lsu_align, purely combinational, SHALL implement load extraction/extension and store lane merge; lsu_rmw_ctrl holds all sequential logic.

Verification
REQ-020 Word 0x10 preloaded 0x8899AABB; lb at 0x11 -> rsp_rdata 0xFFFFFFAA, 2 cycles after acceptance; lbu at 0x11 -> 0x000000AA.
REQ-021 Word 0x10 = 0x8899AABB; sb 0x11 data 0x000000CC -> READ then WRITE with mem_wdata 0x8899CCBB, rsp_valid 3 cycles after acceptance; a subsequent lw 0x10 returns 0x8899CCBB.
REQ-022 sw 0x20 data 0xDEADBEEF -> no mem_read, one mem_write, rsp_err 0; lh 0x22 -> 0xFFFFDEAD.
REQ-023 lw 0x13, lh 0x21, req_size 11, and lw 0x400 (DMEM_WORDS = 256) -> each gives rsp_valid = 1 and rsp_err = 1 one cycle after acceptance, with mem_read = mem_write = 0 throughout.
REQ-024 Reset asserted mid-cycle during the WRITE of sh 0x30 -> outputs drop asynchronously, memory word unchanged, no rsp_valid, req_ready = 1.
REQ-025 Back-to-back req_valid held high -> exactly one acceptance per IDLE visit, no requests lost or duplicated, rsp_valid count equals acceptance count.
